// File: rtl/counter_sched_if.sv
// Requester-side bus of the shared-counter scheduler.
// With CNT_SCHED_HOLD_EN defined the bus also carries a hold input that freezes a run.
interface counter_sched_if #(
   parameter int NREQ = 4,
   parameter int CW   = 3,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic [NREQ-1:0]    gnt;
   logic [IDW-1:0]     owner;
   logic               busy;
   logic [CW-1:0]      count;
   logic [NREQ-1:0]    done;
`ifdef CNT_SCHED_HOLD_EN
   logic               hold;

   modport master (output req, len, hold, input gnt, owner, busy, count, done);
   modport slave  (input req, len, hold, output gnt, owner, busy, count, done);
`else
   modport master (output req, len, input gnt, owner, busy, count, done);
   modport slave  (input req, len, output gnt, owner, busy, count, done);
`endif
endinterface

// File: rtl/counter_sched.sv
// Round-robin arbiter + sequencer sharing one up-counter among NREQ requesters.
// Optional feature macro: CNT_SCHED_HOLD_EN (adds a hold input that freezes a run).
module counter_sched_lane (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic fin,
   input  logic clr,
   input  logic sel,
   input  logic own,
   output logic gnt,
   output logic done
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= fin & own;
         if (start && sel)
            gnt <= 1'b1;
         else if (clr)
            gnt <= 1'b0;
      end
   end
endmodule

module counter_sched #(
   parameter int NREQ = 4,
   parameter int CW   = 3,
   parameter int IDW  = 2
) (
   input  logic clk,
   input  logic rst,
   counter_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  owner_r;
   logic [CW-1:0]   len_r;
   logic [CW-1:0]   count_r;
   logic            busy_r;
   logic [NREQ-1:0] gnt_v;
   logic [NREQ-1:0] done_v;

   logic            hold_i;
   logic            win_vld;
   logic [IDW-1:0]  win;
   logic [IDW:0]    sum;
   logic [IDW:0]    nxt;
   logic            start;
   logic            fin;
   logic            clr;

`ifdef CNT_SCHED_HOLD_EN
   assign hold_i = bus.hold;
`else
   assign hold_i = 1'b0;
`endif

   // Scan from ptr upward (mod NREQ); iterating high-to-low lets the closest hit win.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      sum     = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ))
            sum = sum - (IDW+1)'(NREQ);
         if (bus.req[sum[IDW-1:0]]) begin
            win_vld = 1'b1;
            win     = sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      nxt = {1'b0, owner_r} + 1'b1;
      if (nxt >= (IDW+1)'(NREQ))
         nxt = '0;
   end

   assign start = (state == IDLE) && win_vld;
   assign fin   = (state == RUN) && !hold_i && (count_r == len_r);
   assign clr   = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ptr     <= '0;
         owner_r <= '0;
         len_r   <= '0;
         count_r <= '0;
         busy_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               count_r <= '0;
               if (win_vld) begin
                  owner_r <= win;
                  len_r   <= bus.len[int'(win)*CW +: CW];
                  busy_r  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               // hold freezes both the increment and the terminal check
               if (!hold_i) begin
                  if (count_r == len_r)
                     state <= DONE;
                  else
                     count_r <= count_r + 1'b1;
               end
            end
            DONE: begin
               ptr     <= nxt[IDW-1:0];
               owner_r <= '0;
               count_r <= '0;
               busy_r  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      counter_sched_lane u_lane (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .fin   (fin),
         .clr   (clr),
         .sel   (win == IDW'(i)),
         .own   (owner_r == IDW'(i)),
         .gnt   (gnt_v[i]),
         .done  (done_v[i])
      );
   end

   assign bus.gnt   = gnt_v;
   assign bus.done  = done_v;
   assign bus.owner = owner_r;
   assign bus.busy  = busy_r;
   assign bus.count = count_r;
endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: expected completions are queued at stimulus time
// and popped when a done pulse appears.
module tb_counter_sched;
   localparam int NREQ = 4;
   localparam int CW   = 3;
   localparam int IDW  = 2;

   typedef struct {
      logic [NREQ-1:0] dn;
      logic [IDW-1:0]  own;
      logic [CW-1:0]   cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   npass;
   int   ntot;
   exp_t sbq[$];

   counter_sched_if #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) bus ();

   counter_sched #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input int own, input int cnt);
      exp_t e;
      e.dn  = NREQ'(1) << own;
      e.own = IDW'(own);
      e.cnt = CW'(cnt);
      sbq.push_back(e);
   endtask

   // Wait (bounded) for a done pulse, then compare it against the oldest queued expectation.
   task automatic wait_done(input string tag, input int budget);
      exp_t e;
      for (int c = 0; c < budget; c++) begin
         if (bus.done != '0) break;
         tick();
      end
      if (sbq.size() == 0) begin
         chk({tag, "_sbq_empty"}, 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_done"},  32'(bus.done),  32'(e.dn));
         chk({tag, "_owner"}, 32'(bus.owner), 32'(e.own));
         chk({tag, "_count"}, 32'(bus.count), 32'(e.cnt));
         chk({tag, "_gnt"},   32'(bus.gnt),   32'(e.dn));
         chk({tag, "_busy"},  32'(bus.busy),  32'd1);
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   initial begin
      npass   = 0;
      ntot    = 0;
      rst     = 1'b0;
      bus.req = '0;
      bus.len = '0;
`ifdef CNT_SCHED_HOLD_EN
      bus.hold = 1'b0;
`endif
      tick();
      tick();
      chk("rst_gnt",   32'(bus.gnt),   32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_busy",  32'(bus.busy),  32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_done",  32'(bus.done),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // reset asserted mid-run clears outputs before any edge
      bus.req = 4'b0001;
      bus.len[0*CW +: CW] = 3'd5;
      tick();
      bus.req = '0;
      tick();
      tick();
      tick();
      chk("midrst_count_pre", 32'(bus.count), 32'd3);
      rst = 1'b0;
      #1;
      chk("midrst_gnt",   32'(bus.gnt),   32'd0);
      chk("midrst_busy",  32'(bus.busy),  32'd0);
      chk("midrst_count", 32'(bus.count), 32'd0);
      chk("midrst_done",  32'(bus.done),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      chk("midrst_idle_gnt", 32'(bus.gnt), 32'd0);

      // single run, len0=3; len change during RUN must be ignored
      bus.req = 4'b0001;
      bus.len[0*CW +: CW] = 3'd3;
      push(0, 3);
      tick();
      chk("single_gnt",   32'(bus.gnt),   32'b0001);
      chk("single_busy",  32'(bus.busy),  32'd1);
      chk("single_c0",    32'(bus.count), 32'd0);
      bus.req = '0;
      bus.len[0*CW +: CW] = 3'd7;
      tick();
      chk("single_c1", 32'(bus.count), 32'd1);
      tick();
      chk("single_c2", 32'(bus.count), 32'd2);
      tick();
      chk("single_c3", 32'(bus.count), 32'd3);
      chk("single_nodone", 32'(bus.done), 32'd0);
      tick();
      wait_done("single", 4);
      tick();
      chk("single_idle_gnt",   32'(bus.gnt),   32'd0);
      chk("single_idle_done",  32'(bus.done),  32'd0);
      chk("single_idle_busy",  32'(bus.busy),  32'd0);
      chk("single_idle_count", 32'(bus.count), 32'd0);

      // round-robin from ptr=0 with all lengths zero
      pulse_reset();
      bus.len = '0;
      bus.req = 4'b1111;
      push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(0, 0);
      for (int r = 0; r < 5; r++) begin
         wait_done($sformatf("rr%0d", r), 6);
         if (r == 4) bus.req = '0;
         tick();
         chk($sformatf("rr%0d_gap_gnt", r),  32'(bus.gnt),  32'd0);
         chk($sformatf("rr%0d_gap_done", r), 32'(bus.done), 32'd0);
      end

      // full-range run: count 0..7 without wrapping
      bus.req = 4'b0100;
      bus.len[2*CW +: CW] = 3'd7;
      push(2, 7);
      tick();
      bus.req = '0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("full_c%0d", k), 32'(bus.count), 32'(k));
         chk($sformatf("full_nodone%0d", k), 32'(bus.done), 32'd0);
         tick();
      end
      wait_done("full", 2);
      tick();
      chk("full_idle_done", 32'(bus.done), 32'd0);

      // pointer fairness: ptr is now 3, so 3 wins before 1
      bus.len = '0;
      bus.req = 4'b1010;
      push(3, 0); push(1, 0);
      wait_done("fair0", 6);
      tick();
      wait_done("fair1", 6);
      bus.req = '0;
      tick();
      tick();
      chk("fair_idle_gnt", 32'(bus.gnt), 32'd0);

`ifdef CNT_SCHED_HOLD_EN
      // hold for three edges while count=1: six RUN cycles in total
      bus.req = 4'b0001;
      bus.len[0*CW +: CW] = 3'd2;
      push(0, 2);
      tick();
      bus.req = '0;
      chk("hold_c0", 32'(bus.count), 32'd0);
      tick();
      chk("hold_c1", 32'(bus.count), 32'd1);
      bus.hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         tick();
         chk($sformatf("hold_frz%0d", h), 32'(bus.count), 32'd1);
         chk($sformatf("hold_gnt%0d", h), 32'(bus.gnt),   32'b0001);
      end
      bus.hold = 1'b0;
      tick();
      chk("hold_c2", 32'(bus.count), 32'd2);
      chk("hold_nodone", 32'(bus.done), 32'd0);
      tick();
      wait_done("hold", 1);
      tick();
`endif

      chk("sbq_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
